score_display: RTL and testbench

Scoreboard driver downstream of the game-logic `player` stage. It consumes the two 2-bit scores and the `gamestate` flag and time-multiplexes them onto a 4-digit, common-anode seven-segment display. It flashes the scoring side's decimal point on each point and blinks the winner's digit at game end. It holds a small state machine, a refresh divider and a blink timer. It never feeds back into game logic.

---
 rtl/score_display.sv | 214 +++++++++++++++++++++
 tb/tb_score_display.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_display.sv
// rtl/score_display.sv - four-digit seven-segment scoreboard driver for the pong score stage
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   leftpscore   in   left player score 0..3
//   rightpscore  in   right player score 0..3
//   gamestate    in   1 = game in progress
//   seg          out  active-low segments g f e d c b a (bit0 = a)
//   an           out  active-low digit enables, an[3] = leftmost
//   dp           out  active-low decimal point of the enabled digit
//   winner       out  00 none, 10 left won, 01 right won

module score_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000,
    parameter int WIN_BLINKS  = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] leftpscore,
    input  logic [1:0] rightpscore,
    input  logic       gamestate,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic [1:0] winner
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam int HW = (WIN_BLINKS > 1) ? $clog2(WIN_BLINKS) : 1;

    localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [HW-1:0] HALF_LAST  = HW'(WIN_BLINKS - 1);

    localparam logic [6:0] G_DASH  = 7'b0111111;
    localparam logic [6:0] G_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, PLAY, WIN_BLINK, WIN_HOLD} state_t;

    function automatic logic [6:0] digit_glyph(input logic [1:0] v);
        case (v)
            2'd0:    digit_glyph = 7'b1000000;
            2'd1:    digit_glyph = 7'b1111001;
            2'd2:    digit_glyph = 7'b0100100;
            default: digit_glyph = 7'b0110000;
        endcase
    endfunction

    state_t          state_q;
    logic [1:0]      left_q, right_q, left_prev_q, right_prev_q;
    logic            gs_q, gs_prev_q;
    logic [RW-1:0]   ref_cnt_q;
    logic [1:0]      digit_q;
    logic [BW-1:0]   blink_cnt_q;
    logic [HW-1:0]   half_q;
    logic            lflash_q, rflash_q;
    logic [BW-1:0]   lflash_cnt_q, rflash_cnt_q;
    logic [1:0]      winner_q;
    logic [6:0]      seg_q, seg_d;
    logic [3:0]      an_q, an_d;
    logic            dp_q, dp_d;

    logic gs_rise, gs_fall, l_point, r_point, blank_hit;

    assign gs_rise = gs_q & ~gs_prev_q;
    assign gs_fall = ~gs_q & gs_prev_q;
    // A score returning to 0 is a new-game clear, not a point.
    assign l_point = (left_q != left_prev_q) && (left_q != 2'd0);
    assign r_point = (right_q != right_prev_q) && (right_q != 2'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            left_q       <= 2'd0;
            right_q      <= 2'd0;
            gs_q         <= 1'b0;
            left_prev_q  <= 2'd0;
            right_prev_q <= 2'd0;
            gs_prev_q    <= 1'b0;
        end else begin
            left_q       <= leftpscore;
            right_q      <= rightpscore;
            gs_q         <= gamestate;
            left_prev_q  <= left_q;
            right_prev_q <= right_q;
            gs_prev_q    <= gs_q;
        end
    end

    // Free-running digit scan, never disturbed by the state machine.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ref_cnt_q <= '0;
            digit_q   <= 2'd0;
        end else if (ref_cnt_q == REF_LAST) begin
            ref_cnt_q <= '0;
            digit_q   <= digit_q + 2'd1;
        end else begin
            ref_cnt_q <= ref_cnt_q + RW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            winner_q     <= 2'b00;
            blink_cnt_q  <= '0;
            half_q       <= '0;
            lflash_q     <= 1'b0;
            rflash_q     <= 1'b0;
            lflash_cnt_q <= '0;
            rflash_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gs_rise) state_q <= PLAY;
                end
                PLAY: begin
                    if (gs_fall) begin
                        lflash_q    <= 1'b0;
                        rflash_q    <= 1'b0;
                        blink_cnt_q <= '0;
                        half_q      <= '0;
                        if (left_q == 2'd3) begin
                            winner_q <= 2'b10;
                            state_q  <= WIN_BLINK;
                        end else if (right_q == 2'd3) begin
                            winner_q <= 2'b01;
                            state_q  <= WIN_BLINK;
                        end else begin
                            winner_q <= 2'b00;
                            state_q  <= IDLE;
                        end
                    end else begin
                        // A fresh point restarts that side's flash from zero.
                        if (l_point) begin
                            lflash_q     <= 1'b1;
                            lflash_cnt_q <= '0;
                        end else if (lflash_q) begin
                            if (lflash_cnt_q == BLINK_LAST) lflash_q <= 1'b0;
                            else lflash_cnt_q <= lflash_cnt_q + BW'(1);
                        end
                        if (r_point) begin
                            rflash_q     <= 1'b1;
                            rflash_cnt_q <= '0;
                        end else if (rflash_q) begin
                            if (rflash_cnt_q == BLINK_LAST) rflash_q <= 1'b0;
                            else rflash_cnt_q <= rflash_cnt_q + BW'(1);
                        end
                    end
                end
                WIN_BLINK: begin
                    if (gs_rise) begin
                        winner_q <= 2'b00;
                        state_q  <= PLAY;
                    end else if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_q <= '0;
                        if (half_q == HALF_LAST) state_q <= WIN_HOLD;
                        else half_q <= half_q + HW'(1);
                    end else begin
                        blink_cnt_q <= blink_cnt_q + BW'(1);
                    end
                end
                WIN_HOLD: begin
                    if (gs_rise) begin
                        winner_q <= 2'b00;
                        state_q  <= PLAY;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Odd half-periods (half_q[0] = 1) blank the winner's digit.
    assign blank_hit = (state_q == WIN_BLINK) && half_q[0] &&
                       (((digit_q == 2'd3) && (winner_q == 2'b10)) ||
                        ((digit_q == 2'd0) && (winner_q == 2'b01)));

    always_comb begin
        an_d = ~(4'b0001 << digit_q);
        dp_d = 1'b1;
        case (digit_q)
            2'd3:    seg_d = digit_glyph(left_q);
            2'd0:    seg_d = digit_glyph(right_q);
            default: seg_d = G_DASH;
        endcase
        if (state_q == IDLE) seg_d = G_DASH;
        if (blank_hit) seg_d = G_BLANK;
        if ((state_q == PLAY) &&
            (((digit_q == 2'd3) && lflash_q) || ((digit_q == 2'd0) && rflash_q)))
            dp_d = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg_q <= G_BLANK;
            an_q  <= 4'b1111;
            dp_q  <= 1'b1;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
            dp_q  <= dp_d;
        end
    end

    assign seg    = seg_q;
    assign an     = an_q;
    assign dp     = dp_q;
    assign winner = winner_q;

endmodule

// File: tb/tb_score_display.sv
// tb/tb_score_display.sv - self-checking bench for score_display

module tb_score_display;

    localparam int RD = 4;
    localparam int BD = 8;
    localparam int WB = 4;

    localparam int S_IDLE  = 0;
    localparam int S_PLAY  = 1;
    localparam int S_BLINK = 2;
    localparam int S_HOLD  = 3;

    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] leftpscore, rightpscore;
    logic       gamestate;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic [1:0] winner;

    score_display #(.REFRESH_DIV(RD), .BLINK_DIV(BD), .WIN_BLINKS(WB)) dut (
        .clock(clock), .reset(reset), .leftpscore(leftpscore), .rightpscore(rightpscore),
        .gamestate(gamestate), .seg(seg), .an(an), .dp(dp), .winner(winner)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: history of applied inputs indexed by edge number since reset.
    int         n;
    int         st;
    int         win;
    int         win_entry;
    int         l_trig, r_trig;
    logic [1:0] hl[$];
    logic [1:0] hr[$];
    logic       hg[$];
    logic [6:0] exp_seg;
    logic [3:0] exp_an;
    logic       exp_dp;
    logic [1:0] exp_win;

    function automatic int L(int k);
        if (k < 1 || k > hl.size()) return 0;
        return int'(hl[k-1]);
    endfunction
    function automatic int R(int k);
        if (k < 1 || k > hr.size()) return 0;
        return int'(hr[k-1]);
    endfunction
    function automatic int G(int k);
        if (k < 1 || k > hg.size()) return 0;
        return int'(hg[k-1]);
    endfunction

    function automatic logic [6:0] glyph(int v);
        case (v)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            default: return 7'b0110000;
        endcase
    endfunction

    function automatic bit flash_on(int t, int m);
        return (t >= 1) && (m >= t) && (m < t + BD);
    endfunction

    task automatic model_reset();
        n = 0; st = S_IDLE; win = 0; win_entry = 0;
        l_trig = -100; r_trig = -100;
        hl.delete(); hr.delete(); hg.delete();
        exp_seg = BLANK; exp_an = 4'b1111; exp_dp = 1'b1; exp_win = 2'b00;
    endtask

    task automatic model_step();
        int old, idx, lq, rq, lp, rp, gq, gp;
        logic [6:0] s;
        old = n;
        n = n + 1;
        idx = (old / RD) % 4;
        lq = L(old);   rq = R(old);
        lp = L(old-1); rp = R(old-1);
        gq = G(old);   gp = G(old-1);

        if (st == S_IDLE)  s = DASH;
        else if (idx == 3) s = glyph(lq);
        else if (idx == 0) s = glyph(rq);
        else               s = DASH;
        if (st == S_BLINK && (((old - win_entry) / BD) % 2 == 1) &&
            ((idx == 3 && win == 2) || (idx == 0 && win == 1)))
            s = BLANK;
        exp_seg = s;
        exp_an  = ~(4'b0001 << idx);
        exp_dp  = !(st == S_PLAY && ((idx == 3 && flash_on(l_trig, old)) ||
                                     (idx == 0 && flash_on(r_trig, old))));

        case (st)
            S_IDLE: if (gq == 1 && gp == 0) st = S_PLAY;
            S_PLAY: begin
                if (gq == 0 && gp == 1) begin
                    l_trig = -100; r_trig = -100;
                    if (lq == 3)      begin win = 2; st = S_BLINK; win_entry = n; end
                    else if (rq == 3) begin win = 1; st = S_BLINK; win_entry = n; end
                    else              begin win = 0; st = S_IDLE; end
                end else begin
                    if (lq != lp && lq != 0) l_trig = n;
                    if (rq != rp && rq != 0) r_trig = n;
                end
            end
            S_BLINK: begin
                if (gq == 1 && gp == 0)          begin win = 0; st = S_PLAY; end
                else if (n - win_entry == WB * BD) st = S_HOLD;
            end
            default: if (gq == 1 && gp == 0) begin win = 0; st = S_PLAY; end
        endcase
        exp_win = 2'(win);

        hl.push_back(leftpscore);
        hr.push_back(rightpscore);
        hg.push_back(gamestate);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: dut=%0h expected=%0h t=%0t", name, act, expv, $time);
        end
    endtask

    task automatic chk_all();
        chk("seg", {25'd0, seg}, {25'd0, exp_seg});
        chk("an", {28'd0, an}, {28'd0, exp_an});
        chk("dp", {31'd0, dp}, {31'd0, exp_dp});
        chk("winner", {30'd0, winner}, {30'd0, exp_win});
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        @(negedge clock);
        chk_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        chk_all();
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk_all();
        reset = 1'b0;
    endtask

    task automatic drive(int l, int r, int g);
        leftpscore  = 2'(l);
        rightpscore = 2'(r);
        gamestate   = 1'(g);
    endtask

    task automatic idle_scan();
        logic [3:0] e;
        for (int k = 0; k < 16; k++) begin
            step();
            e = ~(4'b0001 << (k / 4));
            chk("scan_an", {28'd0, an}, {28'd0, e});
            chk("scan_seg", {25'd0, seg}, {25'd0, DASH});
        end
    endtask

    task automatic wait_an(logic [3:0] target);
        bit found = 0;
        for (int j = 0; j < 20 && !found; j++) begin
            step();
            if (an == target) found = 1;
        end
        chk("wait_an", {28'd0, an}, {28'd0, target});
    endtask

    typedef struct {
        logic [1:0] l;
        logic [1:0] r;
        logic       g;
        logic [3:0] an_at;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] win;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int hold;
        drive(0, 0, 0);
        reset = 1'b0;
        @(negedge clock);
        do_reset();
        idle_scan();

        tbl[0] = '{2'd0, 2'd0, 1'b0, 4'b0111, DASH,       1'b1, 2'b00};
        tbl[1] = '{2'd0, 2'd0, 1'b1, 4'b0111, 7'b1000000, 1'b1, 2'b00};
        tbl[2] = '{2'd2, 2'd1, 1'b1, 4'b0111, 7'b0100100, 1'b1, 2'b00};
        tbl[3] = '{2'd2, 2'd1, 1'b1, 4'b1110, 7'b1111001, 1'b1, 2'b00};
        tbl[4] = '{2'd2, 2'd1, 1'b1, 4'b1011, DASH,       1'b1, 2'b00};
        tbl[5] = '{2'd2, 2'd1, 1'b1, 4'b1101, DASH,       1'b1, 2'b00};
        tbl[6] = '{2'd3, 2'd3, 1'b1, 4'b1110, 7'b0110000, 1'b1, 2'b00};
        tbl[7] = '{2'd3, 2'd3, 1'b0, 4'b1110, 7'b0110000, 1'b1, 2'b10};
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].l, tbl[i].r, tbl[i].g);
            repeat (12) step();
            wait_an(tbl[i].an_at);
            chk("tbl_seg", {25'd0, seg}, {25'd0, tbl[i].seg});
            chk("tbl_dp", {31'd0, dp}, {31'd0, tbl[i].dp});
            chk("tbl_win", {30'd0, winner}, {30'd0, tbl[i].win});
        end

        // Blink finishes; left digit steady in hold.
        repeat (40) step();
        wait_an(4'b0111);
        chk("hold_seg", {25'd0, seg}, {25'd0, 7'b0110000});
        chk("hold_win", {30'd0, winner}, {30'd0, 2'b10});

        // Back to play; right point flashes, left clear does not.
        drive(2, 1, 1);
        repeat (14) step();
        drive(2, 2, 1);
        cnt = 0;
        for (int k = 0; k < 14; k++) begin
            step();
            if (an == 4'b1110 && dp == 1'b0) cnt++;
        end
        chk("flash_seen", {31'd0, cnt > 0}, 32'd1);
        drive(0, 2, 1);
        cnt = 0;
        for (int k = 0; k < 14; k++) begin
            step();
            if (dp == 1'b0) cnt++;
        end
        chk("no_flash_on_clear", cnt, 0);

        // Left win, then restart during blink.
        drive(3, 2, 1);
        repeat (4) step();
        drive(3, 2, 0);
        repeat (2) step();
        chk("win_left", {30'd0, winner}, {30'd0, 2'b10});
        repeat (4) step();
        drive(3, 2, 1);
        repeat (2) step();
        chk("restart_win", {30'd0, winner}, {30'd0, 2'b00});
        repeat (20) step();

        // Game ends with no one at 3.
        drive(0, 1, 1);
        repeat (4) step();
        drive(0, 1, 0);
        repeat (2) step();
        chk("no_winner", {30'd0, winner}, {30'd0, 2'b00});
        wait_an(4'b0111);
        chk("idle_dash", {25'd0, seg}, {25'd0, DASH});

        // Reset in the middle of a blink.
        drive(1, 3, 1);
        repeat (6) step();
        drive(1, 3, 0);
        repeat (12) step();
        chk("right_win", {30'd0, winner}, {30'd0, 2'b01});
        do_reset();
        idle_scan();

        // Random play checked cycle by cycle against the model.
        for (int it = 0; it < 500; it++) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1));
            hold = $urandom_range(1, 30);
            repeat (hold) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
